// File: rtl/seg_disp_pkg.sv
// Shared display definitions for the board's 7-segment blocks.
//   - GLYPH_*    : active-high glyphs, bit order {g,f,e,d,c,b,a}
//   - scan_state_e : per-slot scan state (ST_BLANK, ST_ON)
package seg_disp_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } scan_state_e;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h7C;
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_D     = 7'h5E;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_F     = 7'h71;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to 7-segment glyph decoder (active-high).
//   nibble_i : 4-bit value 0..F
//   seg_o    : segments {g,f,e,d,c,b,a}, 1 = lit
module hex_to_7seg
  import seg_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = GLYPH_BLANK;
    case (nibble_i)
      4'h0: seg_o = GLYPH_0;
      4'h1: seg_o = GLYPH_1;
      4'h2: seg_o = GLYPH_2;
      4'h3: seg_o = GLYPH_3;
      4'h4: seg_o = GLYPH_4;
      4'h5: seg_o = GLYPH_5;
      4'h6: seg_o = GLYPH_6;
      4'h7: seg_o = GLYPH_7;
      4'h8: seg_o = GLYPH_8;
      4'h9: seg_o = GLYPH_9;
      4'hA: seg_o = GLYPH_A;
      4'hB: seg_o = GLYPH_B;
      4'hC: seg_o = GLYPH_C;
      4'hD: seg_o = GLYPH_D;
      4'hE: seg_o = GLYPH_E;
      4'hF: seg_o = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment scan controller.
//   clk, rst    : clock, synchronous active-high reset
//   digit_data  : hex nibble per digit, digit k = [4k+3:4k]
//   dp_in       : decimal point per digit, 1 = lit
//   digit_en    : 1 = digit shown, 0 = its slot stays dark
//   an          : anode drives (one-hot asserted or all inactive)
//   seg, dp     : segments {g,f,e,d,c,b,a} and decimal point
//   digit_idx   : index of the current slot
//   frame_tick  : 1-clock pulse when the scan wraps back to slot 0
module seven_seg_scan_ctrl
  import seg_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned DIV_COUNT     = 200_000,
  parameter int unsigned BLANK_CYCLES  = 2_000,
  parameter bit          ANODE_ACT_LOW = 1'b1,
  parameter bit          SEG_ACT_LOW   = 1'b1,
  localparam int         CW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1,
  localparam int         IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [IW-1:0]           digit_idx,
  output logic                    frame_tick
);

  localparam logic [CW-1:0] SLOT_LAST = CW'(DIV_COUNT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam scan_state_e   ST_INIT   = (BLANK_CYCLES == 0) ? ST_ON : ST_BLANK;

  // Inactive levels for the pins; XOR with these applies polarity.
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ANODE_ACT_LOW}};
  localparam logic [6:0]            SEG_OFF = {7{SEG_ACT_LOW}};

  logic [CW-1:0]           slot_q, slot_d;
  logic [IW-1:0]           idx_q, idx_d;
  scan_state_e             state_q, state_d;
  logic                    slot_end, frame_end, blank_d;

  logic [4*NUM_DIGITS-1:0] shadow_data_q;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_en_q;

  logic [3:0]              cur_nibble;
  logic [6:0]              cur_glyph;
  logic                    on_sel;
  logic [NUM_DIGITS-1:0]   an_d, an_q;
  logic [6:0]              seg_d, seg_q;
  logic                    dp_d, dp_q, frame_tick_q;

  // Counters and next scan state.
  always_comb begin
    slot_end  = (slot_q == SLOT_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);
    slot_d    = slot_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end) begin
      slot_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    state_d = blank_d ? ST_BLANK : ST_ON;
  end

  // The blank window is a function of the next slot count, so the state
  // register always agrees with slot_q. With no blank window it is never BLANK.
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign blank_d = 1'b0;
  end else begin : g_blank
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);
    assign blank_d = (slot_d < BLANK_LIM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q  <= '0;
      idx_q   <= '0;
      state_q <= ST_INIT;
    end else begin
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

  // Shadow registers: follow the inputs in reset, then reload only on the
  // last clock of a frame so a frame is never shown half old, half new.
  always_ff @(posedge clk) begin
    if (rst || frame_end) begin
      shadow_data_q <= digit_data;
      shadow_dp_q   <= dp_in;
      shadow_en_q   <= digit_en;
    end
  end

  assign cur_nibble = shadow_data_q[{idx_q, 2'b00} +: 4];

  hex_to_7seg u_dec (
    .nibble_i (cur_nibble),
    .seg_o    (cur_glyph)
  );

  // Output mux in active-high terms, then polarity.
  always_comb begin
    on_sel      = (state_q == ST_ON) && shadow_en_q[idx_q];
    an_d        = '0;
    an_d[idx_q] = on_sel;
    an_d        = an_d ^ AN_OFF;
    seg_d       = (on_sel ? cur_glyph : GLYPH_BLANK) ^ SEG_OFF;
    dp_d        = (on_sel && shadow_dp_q[idx_q]) ^ SEG_ACT_LOW;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= SEG_ACT_LOW;
      frame_tick_q <= 1'b0;
    end else begin
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_end;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;
  assign digit_idx  = idx_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
module tb_seven_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int DIV   = 10;
  localparam int BLK   = 2;
  localparam int FRAME = N * DIV;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [15:0] digit_data = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  logic        rst1 = 1'b1;
  logic [3:0]  dd1 = '0;
  logic [0:0]  dpi1 = '0;
  logic [0:0]  en1 = '0;
  logic [0:0]  an1;
  logic [6:0]  seg1;
  logic        dpo1;
  logic [0:0]  idx1;
  logic        ft1;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(N), .DIV_COUNT(DIV), .BLANK_CYCLES(BLK),
    .ANODE_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)
  ) u_dut (
    .clk(clk), .rst(rst), .digit_data(digit_data), .dp_in(dp_in),
    .digit_en(digit_en), .an(an), .seg(seg), .dp(dp),
    .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(1), .DIV_COUNT(DIV), .BLANK_CYCLES(0),
    .ANODE_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)
  ) u_dut1 (
    .clk(clk), .rst(rst1), .digit_data(dd1), .dp_in(dpi1),
    .digit_en(en1), .an(an1), .seg(seg1), .dp(dpo1),
    .digit_idx(idx1), .frame_tick(ft1)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[v];
  endfunction

  // cyc = clock edges since reset released; the frame contents are the
  // inputs seen at reset or on the edge that closed the previous frame.
  int          cyc = 0;
  logic [15:0] snap_data;
  logic [3:0]  snap_dp, snap_en;
  logic [3:0]  exp_an  = 4'hF;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_dp  = 1'b1;
  logic        exp_ft  = 1'b0;
  logic [1:0]  exp_idx = 2'd0;

  always @(posedge clk) begin
    if (rst) begin
      cyc = 0;
      snap_data = digit_data; snap_dp = dp_in; snap_en = digit_en;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_ft = 1'b0; exp_idx = 2'd0;
    end else begin
      int  s, k;
      bit  lit;
      s   = cyc % DIV;
      k   = (cyc / DIV) % N;
      lit = (s >= BLK) && snap_en[k];
      exp_an  = lit ? ~(4'b0001 << k) : 4'hF;
      exp_seg = lit ? ~glyph(snap_data[4*k +: 4]) : 7'h7F;
      exp_dp  = lit ? ~snap_dp[k] : 1'b1;
      cyc     = cyc + 1;
      exp_ft  = (cyc % FRAME) == 0;
      exp_idx = 2'((cyc / DIV) % N);
      if (exp_ft) begin
        snap_data = digit_data; snap_dp = dp_in; snap_en = digit_en;
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    digit_data = 16'h3210; dp_in = 4'h0; digit_en = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset c=%0d an=%b seg=%b dp=%b ft=%b expected an=1111 seg=1111111 dp=1 ft=0",
                 c, an, seg, dp, frame_tick);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_scan();
    for (int j = 1; j <= FRAME; j++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_tick, digit_idx} !== {exp_an, exp_seg, exp_dp, exp_ft, exp_idx}) begin
        errors++;
        $display("FAIL basic j=%0d got an=%b seg=%b dp=%b ft=%b idx=%0d want an=%b seg=%b dp=%b ft=%b idx=%0d",
                 j, an, seg, dp, frame_tick, digit_idx, exp_an, exp_seg, exp_dp, exp_ft, exp_idx);
      end
      if (j == 3 || j == 9 || j == 13 || j == 10) begin
        checks++;
        if ((j == 3 && {an, seg} !== {4'b1110, 7'b1000000}) ||
            (j == 9 && digit_idx !== 2'd0) ||
            (j == 10 && digit_idx !== 2'd1) ||
            (j == 13 && {an, seg} !== {4'b1101, 7'b1111001})) begin
          errors++;
          $display("FAIL basic_spot j=%0d an=%b seg=%b idx=%0d", j, an, seg, digit_idx);
        end
      end
    end
  endtask

  task automatic test_frame_atomicity();
    int ticks = 0;
    while (cyc < 3 * FRAME) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_tick, digit_idx} !== {exp_an, exp_seg, exp_dp, exp_ft, exp_idx}) begin
        errors++;
        $display("FAIL atomic cyc=%0d got an=%b seg=%b dp=%b ft=%b idx=%0d want an=%b seg=%b dp=%b ft=%b idx=%0d",
                 cyc, an, seg, dp, frame_tick, digit_idx, exp_an, exp_seg, exp_dp, exp_ft, exp_idx);
      end
      if (frame_tick) ticks++;
      if (cyc == 73 || cyc == 83) begin
        checks++;
        if ((cyc == 73 && {an, seg} !== {4'b0111, ~7'h4F}) ||
            (cyc == 83 && {an, seg} !== {4'b1110, ~7'h39})) begin
          errors++;
          $display("FAIL atomic_spot cyc=%0d an=%b seg=%b", cyc, an, seg);
        end
      end
      if (cyc == 55) digit_data = 16'hFEDC;
    end
    checks++;
    if (ticks != 2) begin
      errors++;
      $display("FAIL frame_tick_count got=%0d want=2", ticks);
    end
  endtask

  task automatic test_disable_dp();
    int dark_bad = 0;
    int dp_lit = 0;
    rst = 1'b1;
    digit_data = 16'(($urandom & 32'hFFFF)); digit_en = 4'b1010; dp_in = 4'b0010;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int j = 1; j <= FRAME; j++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_tick, digit_idx} !== {exp_an, exp_seg, exp_dp, exp_ft, exp_idx}) begin
        errors++;
        $display("FAIL disable j=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 j, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if ((((j - 1) / DIV) == 0 || ((j - 1) / DIV) == 2) && an !== 4'hF) dark_bad++;
      if (((j - 1) / DIV) == 1 && dp === 1'b0) dp_lit++;
    end
    checks++;
    if (dark_bad != 0 || dp_lit != DIV - BLK) begin
      errors++;
      $display("FAIL disable_spot dark_bad=%0d dp_lit=%0d want 0 and %0d", dark_bad, dp_lit, DIV - BLK);
    end
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    while (cyc != FRAME + 26 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({an, seg, dp, frame_tick, digit_idx} !== {4'hF, 7'h7F, 1'b1, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL mid_reset an=%b seg=%b dp=%b ft=%b idx=%0d guard=%0d", an, seg, dp, frame_tick, digit_idx, guard);
    end
    rst = 1'b0;
    for (int j = 1; j <= 45; j++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_tick, digit_idx} !== {exp_an, exp_seg, exp_dp, exp_ft, exp_idx}) begin
        errors++;
        $display("FAIL restart j=%0d got an=%b seg=%b dp=%b ft=%b idx=%0d want an=%b seg=%b dp=%b ft=%b idx=%0d",
                 j, an, seg, dp, frame_tick, digit_idx, exp_an, exp_seg, exp_dp, exp_ft, exp_idx);
      end
    end
  endtask

  task automatic test_random();
    rst = 1'b1;
    digit_data = 16'($urandom); dp_in = 4'($urandom); digit_en = 4'($urandom);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 1; j <= 4 * FRAME; j++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_tick, digit_idx} !== {exp_an, exp_seg, exp_dp, exp_ft, exp_idx}) begin
        errors++;
        $display("FAIL random j=%0d got an=%b seg=%b dp=%b ft=%b idx=%0d want an=%b seg=%b dp=%b ft=%b idx=%0d",
                 j, an, seg, dp, frame_tick, digit_idx, exp_an, exp_seg, exp_dp, exp_ft, exp_idx);
      end
      if ($urandom_range(0, 7) == 0) begin
        digit_data = 16'($urandom); dp_in = 4'($urandom); digit_en = 4'($urandom);
      end
    end
  endtask

  task automatic test_single_digit();
    logic [3:0] d;
    logic       p;
    d = 4'($urandom); p = 1'($urandom);
    dd1 = d; dpi1 = p; en1 = 1'b1;
    @(negedge clk);
    checks++;
    if ({an1, seg1, dpo1, ft1} !== {1'b1, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_reset an=%b seg=%b dp=%b ft=%b", an1, seg1, dpo1, ft1);
    end
    rst1 = 1'b0;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      checks++;
      if ({an1, seg1, dpo1, ft1, idx1} !== {1'b0, ~glyph(d), ~p, (j % DIV) == 0, 1'b0}) begin
        errors++;
        $display("FAIL single j=%0d got an=%b seg=%b dp=%b ft=%b idx=%0d want an=0 seg=%b dp=%b ft=%b idx=0",
                 j, an1, seg1, dpo1, ft1, idx1, ~glyph(d), ~p, (j % DIV) == 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_frame_atomicity();
    test_disable_dp();
    test_mid_reset();
    test_random();
    test_single_digit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
